// File: rtl/pong_pkg.sv
// Shared pong constants: screen geometry, FSM/direction encodings and small
// helpers used by the ball datapath.
package pong_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 20;

    // Farthest legal top-left corner and the parked (centred) position
    localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]         X_HOME = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         Y_HOME = 10'((SCREEN_H - BALL_SIZE) / 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;

    // Forward means right on X and down on Y
    localparam logic DIR_FWD  = 1'b1;
    localparam logic DIR_BACK = 1'b0;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    function automatic logic [2:0] eff_speed(input logic [2:0] speed);
        return (speed == 3'd0) ? 3'd1 : speed;
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] digit);
        return (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    endfunction

    // One frame of motion on a single axis, clamped to [lo, hi]; reaching a
    // bound reverses direction. Signed math keeps under-runs below zero visible.
    function automatic axis_t axis_advance(input logic [9:0]         pos,
                                           input logic               dir,
                                           input logic [2:0]         spd,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
        axis_t             r;
        logic signed [10:0] p;
        logic signed [10:0] d;
        d     = $signed({8'd0, spd});
        p     = $signed({1'b0, pos});
        r.dir = dir;
        if (dir == DIR_FWD) begin
            p = p + d;
            if (p >= hi) begin
                p     = hi;
                r.dir = DIR_BACK;
            end
        end else begin
            p = p - d;
            if (p <= lo) begin
                p     = lo;
                r.dir = DIR_FWD;
            end
        end
        r.pos = p[9:0];
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick: one-cycle pulse on each falling edge of the active-low vertical
// sync. The history flop resets high so a sync already low at reset is a tick.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vga_vs,
    output logic tick
);

    logic vs_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vs_prev <= 1'b1;
        else       vs_prev <= vga_vs;
    end

    assign tick = vs_prev & ~vga_vs;

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball physics for pong: moves the ball once per frame, bounces it
// off walls and the left paddle, and counts misses as a BCD digit.
module ball_motion
    import pong_pkg::*;
#(
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_H    = 60,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_vs,
    input  logic       launch,
    input  logic [2:0] speed,
    input  logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_play,
    output logic       hit,
    output logic [3:0] miss_count
);

    localparam int                  FC_W    = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [FC_W-1:0]     FC_LAST = FC_W'(MISS_FRAMES - 1);
    localparam logic signed [10:0]  X_MIN   = 11'(PADDLE_X);
    localparam logic signed [10:0]  Y_MIN   = 11'sd0;

    logic            tick;
    logic [1:0]      state,     state_nxt;
    logic [9:0]      x_nxt,     y_nxt;
    logic            dir_x,     dx_nxt;
    logic            dir_y,     dy_nxt;
    logic [2:0]      spd_lat,   spd_nxt;
    logic            hit_nxt;
    logic [3:0]      miss_nxt;
    logic [FC_W-1:0] frame_cnt, fc_nxt;

    axis_t       ax, ay;
    logic [10:0] ball_bot, pad_bot;
    logic        overlap, paddle_contact;

    frame_tick_gen u_frame_tick (
        .clk    (clk),
        .reset  (reset),
        .vga_vs (vga_vs),
        .tick   (tick)
    );

    // Candidate moves for both axes; used only on a tick in MOVE
    always_comb begin
        ax = axis_advance(ball_x, dir_x, spd_lat, X_MIN, X_MAX);
        ay = axis_advance(ball_y, dir_y, spd_lat, Y_MIN, Y_MAX);
    end

    // Paddle test uses the already-resolved Y position of this frame
    assign ball_bot       = {1'b0, ay.pos} + 11'(BALL_SIZE);
    assign pad_bot        = {1'b0, paddle_y} + 11'(PADDLE_H);
    assign overlap        = (ball_bot > {1'b0, paddle_y}) && ({1'b0, ay.pos} < pad_bot);
    assign paddle_contact = (dir_x == DIR_BACK) && (ax.dir == DIR_FWD);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through the case can infer a latch.
        state_nxt = state;
        x_nxt     = ball_x;
        y_nxt     = ball_y;
        dx_nxt    = dir_x;
        dy_nxt    = dir_y;
        spd_nxt   = spd_lat;
        hit_nxt   = 1'b0;
        miss_nxt  = miss_count;
        fc_nxt    = frame_cnt;

        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nxt = ST_MOVE;
                    spd_nxt   = eff_speed(speed);
                end
            end

            ST_MOVE: begin
                if (tick) begin
                    x_nxt  = ax.pos;
                    dx_nxt = ax.dir;
                    y_nxt  = ay.pos;
                    dy_nxt = ay.dir;
                    if (paddle_contact) begin
                        if (overlap) begin
                            hit_nxt = 1'b1;
                        end else begin
                            x_nxt     = 10'd0;
                            dx_nxt    = dir_x;
                            state_nxt = ST_MISS;
                            miss_nxt  = bcd_inc(miss_count);
                            fc_nxt    = '0;
                        end
                    end
                end
            end

            ST_MISS: begin
                if (tick) begin
                    if (frame_cnt == FC_LAST) begin
                        state_nxt = ST_IDLE;
                        x_nxt     = X_HOME;
                        y_nxt     = Y_HOME;
                        dx_nxt    = DIR_FWD;
                    end else begin
                        fc_nxt = frame_cnt + 1'b1;
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ball_x     <= X_HOME;
            ball_y     <= Y_HOME;
            dir_x      <= DIR_FWD;
            dir_y      <= DIR_FWD;
            spd_lat    <= 3'd1;
            hit        <= 1'b0;
            miss_count <= 4'd0;
            frame_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            state      <= state_nxt;
            ball_x     <= x_nxt;
            ball_y     <= y_nxt;
            dir_x      <= dx_nxt;
            dir_y      <= dy_nxt;
            spd_lat    <= spd_nxt;
            hit        <= hit_nxt;
            miss_count <= miss_nxt;
            frame_cnt  <= fc_nxt;
        end
    end

    assign in_play = (state == ST_MOVE);

endmodule

// File: tb/tb_ball_motion.sv
// Randomized scoreboard bench for ball_motion: a frame-level reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_ball_motion;

    localparam int W      = 640;
    localparam int H      = 480;
    localparam int B      = 20;
    localparam int PX     = 16;
    localparam int PH     = 60;
    localparam int MF     = 60;
    localparam int CYCLES = 40000;

    localparam int M_IDLE   = 0;
    localparam int M_PLAY   = 1;
    localparam int M_FROZEN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_vs;
    logic       launch;
    logic [2:0] speed;
    logic [9:0] paddle_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       in_play;
    logic       hit;
    logic [3:0] miss_count;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk        (clk),
        .reset      (reset),
        .vga_vs     (vga_vs),
        .launch     (launch),
        .speed      (speed),
        .paddle_y   (paddle_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .in_play    (in_play),
        .hit        (hit),
        .miss_count (miss_count)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       in_play;
        logic       hit;
        logic [3:0] miss;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_hits   = 0;
    int   n_misses = 0;
    bit   running  = 0;
    int   vs_gap   = 2;

    // Reference model: ball position, velocity sign per axis, mode and counters
    int m_mode, m_x, m_y, m_dx, m_dy, m_spd, m_miss, m_frames;
    bit m_hit, m_prev_vs;

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got x=%0d y=%0d in_play=%0b hit=%0b miss=%0d, want x=%0d y=%0d in_play=%0b hit=%0b miss=%0d",
                     name, $time, got.x, got.y, got.in_play, got.hit, got.miss,
                     want.x, want.y, want.in_play, want.hit, want.miss);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.x       = ball_x;
        o.y       = ball_y;
        o.in_play = in_play;
        o.hit     = hit;
        o.miss    = miss_count;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.x       = 10'(m_x);
        o.y       = 10'(m_y);
        o.in_play = (m_mode == M_PLAY);
        o.hit     = m_hit;
        o.miss    = 4'(m_miss);
        return o;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_x       = (W - B) / 2;
        m_y       = (H - B) / 2;
        m_dx      = 1;
        m_dy      = 1;
        m_spd     = 1;
        m_miss    = 0;
        m_frames  = 0;
        m_hit     = 0;
        m_prev_vs = 1;
    endtask

    // Advance the model by one clock using the inputs seen at this edge
    task automatic model_step();
        bit tick;
        int nx, ny;
        tick      = m_prev_vs && (vga_vs == 1'b0);
        m_prev_vs = vga_vs;
        m_hit     = 0;
        if (m_mode == M_IDLE) begin
            if (launch) begin
                m_mode = M_PLAY;
                m_spd  = (speed == 0) ? 1 : int'(speed);
            end
        end else if (m_mode == M_PLAY && tick) begin
            ny = m_y + m_dy * m_spd;
            nx = m_x + m_dx * m_spd;
            if (m_dy > 0 && ny >= H - B) begin
                ny   = H - B;
                m_dy = -1;
            end else if (m_dy < 0 && ny <= 0) begin
                ny   = 0;
                m_dy = 1;
            end
            if (m_dx > 0 && nx >= W - B) begin
                nx   = W - B;
                m_dx = -1;
            end else if (m_dx < 0 && nx <= PX) begin
                if (ny + B > int'(paddle_y) && ny < int'(paddle_y) + PH) begin
                    nx    = PX;
                    m_dx  = 1;
                    m_hit = 1;
                    n_hits++;
                end else begin
                    nx       = 0;
                    m_mode   = M_FROZEN;
                    m_miss   = (m_miss + 1) % 10;
                    m_frames = 0;
                    n_misses++;
                end
            end
            m_x = nx;
            m_y = ny;
        end else if (m_mode == M_FROZEN && tick) begin
            m_frames++;
            if (m_frames == MF) begin
                m_mode = M_IDLE;
                m_x    = (W - B) / 2;
                m_y    = (H - B) / 2;
                m_dx   = 1;
            end
        end
    endtask

    // Short random frames; paddle tracks the ball half the time so both
    // bounces and misses occur often
    task automatic drive_inputs(input int cyc);
        int p;
        if (vs_gap == 0) begin
            vga_vs = 1'b0;
            vs_gap = $urandom_range(1, 3);
        end else begin
            vga_vs = 1'b1;
            vs_gap--;
        end
        launch = (cyc >= 40) && ($urandom_range(0, 19) == 0);
        speed  = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
            p = m_y - int'($urandom_range(0, 50));
            if (p < 0) p = 0;
            paddle_y = 10'(p);
        end else begin
            paddle_y = 10'($urandom_range(0, 1023));
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle @%0t: got an output cycle, want a queued expectation (queue empty)", $time);
            end else begin
                check("cycle", dut_obs(), exp_q.pop_front());
            end
        end
    end

    initial begin
        reset    = 1'b1;
        vga_vs   = 1'b1;
        launch   = 1'b0;
        speed    = 3'd0;
        paddle_y = 10'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 check("reset_state", dut_obs(), model_obs());
        @(negedge clk);
        reset = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            drive_inputs(cyc);
            @(posedge clk);
            model_step();
            exp_q.push_back(model_obs());
            running = 1;
            if (cyc % 7919 == 7918) begin
                // Reset between edges must take effect before the next edge
                #2 reset = 1'b1;
                #1 model_reset();
                check("async_reset", dut_obs(), model_obs());
                exp_q.delete();
                exp_q.push_back(model_obs());
                #1 reset = 1'b0;
            end
            @(negedge clk);
        end
        #1 running = 0;

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end

        $display("info: %0d paddle bounces and %0d misses exercised", n_hits, n_misses);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
